// File: rtl/ffd4_write_arbiter.sv
// ffd4_write_arbiter: two-requester write arbiter for a shared WIDTH-bit D register.
// Each granted write runs ISSUE (drive d/reset/set for one cycle) then WAIT (commit,
// done pulse). Priority is round-robin on ties, with a bounded burst per owner.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   req_a/op_a/data_a       requester A: request, op (00 hold, 01 load, 10 clear, 11 set), load value
//   req_b/op_b/data_b       requester B: same as A
//   reg_q                   current register output
//   reg_d                   register d input (follows reg_q except in ISSUE)
//   reg_clr, reg_set        register reset/set drives, one-cycle pulses in ISSUE
//   gnt_a, gnt_b            owner of the current transaction (ISSUE and WAIT)
//   done_a, done_b          owner's commit pulse in WAIT
//   busy                    a transaction is in flight
module ffd4_write_arbiter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [1:0]       op_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [1:0]       op_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_clr,
    output logic             reg_set,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic             busy
);

    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SET   = 2'b11;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             last_winner_q, last_winner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             done_a_q, done_a_d;
    logic             done_b_q, done_b_d;
    logic             reg_clr_q, reg_clr_d;
    logic             reg_set_q, reg_set_d;
    logic             busy_q, busy_d;
    logic             win_c;

    // Winner selection, meaningful only at an edge leaving IDLE or WAIT with a request
    always_comb begin
        win_c = SIDE_A;
        if (req_a && req_b) begin
            if (state_q == S_WAIT) begin
                // Current owner keeps the bus until its burst allowance is spent
                win_c = (burst_cnt_q < BURST_LIM) ? last_winner_q : ~last_winner_q;
            end else begin
                win_c = ~last_winner_q;
            end
        end else if (req_b) begin
            win_c = SIDE_B;
        end
    end

    // Next-state, latch and registered-output computation
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        burst_cnt_d   = burst_cnt_q;
        op_d          = op_q;
        data_d        = data_q;

        case (state_q)
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            default: begin
                if (req_a || req_b) begin
                    state_d       = S_ISSUE;
                    last_winner_d = win_c;
                    op_d          = (win_c == SIDE_B) ? op_b : op_a;
                    data_d        = (win_c == SIDE_B) ? data_b : data_a;
                    // Burst length only grows on back-to-back wins out of WAIT
                    if ((state_q == S_WAIT) && (win_c == last_winner_q)) begin
                        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX
                                                               : burst_cnt_q + CNT_W'(1);
                    end else begin
                        burst_cnt_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        gnt_a_d   = busy_d && (last_winner_d == SIDE_A);
        gnt_b_d   = busy_d && (last_winner_d == SIDE_B);
        done_a_d  = (state_d == S_WAIT) && (last_winner_d == SIDE_A);
        done_b_d  = (state_d == S_WAIT) && (last_winner_d == SIDE_B);
        reg_clr_d = (state_d == S_ISSUE) && (op_d == OP_CLEAR);
        reg_set_d = (state_d == S_ISSUE) && (op_d == OP_SET);
    end

    // State and output registers; last winner resets to B so A takes the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_winner_q <= SIDE_B;
            burst_cnt_q   <= '0;
            op_q          <= OP_NOP;
            data_q        <= '0;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            done_a_q      <= 1'b0;
            done_b_q      <= 1'b0;
            reg_clr_q     <= 1'b0;
            reg_set_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            burst_cnt_q   <= burst_cnt_d;
            op_q          <= op_d;
            data_q        <= data_d;
            gnt_a_q       <= gnt_a_d;
            gnt_b_q       <= gnt_b_d;
            done_a_q      <= done_a_d;
            done_b_q      <= done_b_d;
            reg_clr_q     <= reg_clr_d;
            reg_set_q     <= reg_set_d;
            busy_q        <= busy_d;
        end
    end

    // Register d input: hold value except while issuing the latched op
    always_comb begin
        reg_d = reg_q;
        if (state_q == S_ISSUE) begin
            case (op_q)
                OP_LOAD:  reg_d = data_q;
                OP_CLEAR: reg_d = '0;
                OP_SET:   reg_d = '1;
                default:  reg_d = reg_q;
            endcase
        end
    end

    assign reg_clr = reg_clr_q;
    assign reg_set = reg_set_q;
    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign done_a  = done_a_q;
    assign done_b  = done_b_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_ffd4_write_arbiter.sv
// Bench for ffd4_write_arbiter: directed vector table, hand-written corner sequences
// and random traffic, all checked against a transaction-level model of the arbiter
// plus a behavioural model of the 4-bit register it drives.
module tb_ffd4_write_arbiter;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_a, req_b;
    logic [1:0]       op_a, op_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic [WIDTH-1:0] reg_q = 4'b0000;
    logic [WIDTH-1:0] reg_d;
    logic             reg_clr, reg_set, gnt_a, gnt_b, done_a, done_b, busy;

    int n_checks = 0;
    int n_fail   = 0;

    ffd4_write_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .op_a(op_a), .data_a(data_a),
        .req_b(req_b), .op_b(op_b), .data_b(data_b),
        .reg_q(reg_q), .reg_d(reg_d),
        .reg_clr(reg_clr), .reg_set(reg_set),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done_a(done_a), .done_b(done_b), .busy(busy)
    );

    always #5 clk = ~clk;

    // The shared register being arbitrated
    always @(posedge clk) begin
        if (reg_clr)      reg_q <= 4'b0000;
        else if (reg_set) reg_q <= 4'b1111;
        else              reg_q <= reg_d;
    end

    // Transaction-level reference: phase 0 idle, 1 issue, 2 wait; owner 0=A, 1=B
    int         m_phase, m_owner, m_run;
    logic [1:0] m_op;
    logic [3:0] m_data;
    logic [3:0] m_q = 4'b0000;

    task automatic model_reset();
        m_phase = 0;
        m_owner = 1;
        m_run   = 0;
    endtask

    task automatic model_edge();
        int win;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_phase == 1) begin
            case (m_op)
                2'b01:   m_q = m_data;
                2'b10:   m_q = 4'b0000;
                2'b11:   m_q = 4'b1111;
                default: m_q = m_q;
            endcase
            m_phase = 2;
        end else if (!req_a && !req_b) begin
            m_phase = 0;
        end else begin
            if (req_a && req_b) begin
                if (m_phase == 2) win = (m_run < int'(MAX_BURST)) ? m_owner : 1 - m_owner;
                else              win = 1 - m_owner;
            end else begin
                win = req_a ? 0 : 1;
            end
            m_run   = (m_phase == 2 && win == m_owner) ? m_run + 1 : 1;
            m_owner = win;
            m_op    = (win == 1) ? op_b : op_a;
            m_data  = (win == 1) ? data_b : data_a;
            m_phase = 1;
        end
    endtask

    function automatic logic [6:0] model_ctl();
        logic act;
        act = (m_phase != 0);
        return {act && m_owner == 0, act && m_owner == 1,
                m_phase == 2 && m_owner == 0, m_phase == 2 && m_owner == 1,
                m_phase == 1 && m_op == 2'b10, m_phase == 1 && m_op == 2'b11, act};
    endfunction

    function automatic logic [3:0] model_d();
        if (m_phase != 1) return m_q;
        case (m_op)
            2'b01:   return m_data;
            2'b10:   return 4'b0000;
            2'b11:   return 4'b1111;
            default: return m_q;
        endcase
    endfunction

    function automatic logic [6:0] dut_ctl();
        return {gnt_a, gnt_b, done_a, done_b, reg_clr, reg_set, busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("model_ctl", 32'(dut_ctl()), 32'(model_ctl()));
        check("model_reg_d", 32'(reg_d), 32'(model_d()));
        check("model_reg_q", 32'(reg_q), 32'(m_q));
    endtask

    task automatic drive(input logic ra, input logic [1:0] oa, input logic [3:0] da,
                         input logic rb, input logic [1:0] ob, input logic [3:0] db);
        req_a = ra; op_a = oa; data_a = da;
        req_b = rb; op_b = ob; data_b = db;
    endtask

    // One clock: model follows the edge, then everything is compared mid-cycle
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ctl = {gnt_a, gnt_b, done_a, done_b, reg_clr, reg_set, busy}
    typedef struct packed {
        logic       ra;
        logic [1:0] oa;
        logic [3:0] da;
        logic       rb;
        logic [1:0] ob;
        logic [3:0] db;
        logic [6:0] ctl;
        logic [3:0] d;
        logic [3:0] q;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int dones;
        int run_len;
        int last_own;
        int own;

        vecs[0]  = '{1'b1, 2'b01, 4'b0101, 1'b0, 2'b00, 4'b0000, 7'b1000001, 4'b0101, 4'b0000};
        vecs[1]  = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b1010001, 4'b0101, 4'b0101};
        vecs[2]  = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b0000000, 4'b0101, 4'b0101};
        vecs[3]  = '{1'b0, 2'b00, 4'b0000, 1'b1, 2'b11, 4'b0000, 7'b0100011, 4'b1111, 4'b0101};
        vecs[4]  = '{1'b0, 2'b00, 4'b0000, 1'b1, 2'b10, 4'b0000, 7'b0101001, 4'b1111, 4'b1111};
        vecs[5]  = '{1'b0, 2'b00, 4'b0000, 1'b1, 2'b10, 4'b0000, 7'b0100101, 4'b0000, 4'b1111};
        vecs[6]  = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b0101001, 4'b0000, 4'b0000};
        vecs[7]  = '{1'b0, 2'b00, 4'b0000, 1'b1, 2'b11, 4'b0000, 7'b0100011, 4'b1111, 4'b0000};
        vecs[8]  = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b0101001, 4'b1111, 4'b1111};
        vecs[9]  = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b0000000, 4'b1111, 4'b1111};
        vecs[10] = '{1'b1, 2'b01, 4'b0011, 1'b1, 2'b01, 4'b1100, 7'b1000001, 4'b0011, 4'b1111};
        vecs[11] = '{1'b1, 2'b01, 4'b0011, 1'b1, 2'b01, 4'b1100, 7'b1010001, 4'b0011, 4'b0011};
        vecs[12] = '{1'b0, 2'b01, 4'b0011, 1'b1, 2'b01, 4'b1100, 7'b0100001, 4'b1100, 4'b0011};
        vecs[13] = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b0101001, 4'b1100, 4'b1100};
        vecs[14] = '{1'b1, 2'b00, 4'b1010, 1'b0, 2'b00, 4'b0000, 7'b1000001, 4'b1100, 4'b1100};
        vecs[15] = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b1010001, 4'b1100, 4'b1100};
        vecs[16] = '{1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 7'b0000000, 4'b1100, 4'b1100};

        drive(1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000);
        @(negedge clk);
        do_reset();
        check("reset_ctl", 32'(dut_ctl()), 32'd0);
        check("reset_reg_d", 32'(reg_d), 32'(reg_q));

        // Directed vectors: single-requester load/set/clear/nop and a same-edge tie
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ra, vecs[i].oa, vecs[i].da, vecs[i].rb, vecs[i].ob, vecs[i].db);
            tick();
            check($sformatf("vec%0d_ctl", i), 32'(dut_ctl()), 32'(vecs[i].ctl));
            check($sformatf("vec%0d_reg_d", i), 32'(reg_d), 32'(vecs[i].d));
            check($sformatf("vec%0d_reg_q", i), 32'(reg_q), 32'(vecs[i].q));
        end

        // Both held high: done owners must run A x MAX_BURST, B x MAX_BURST, ...
        do_reset();
        dones = 0; run_len = 0; last_own = -1;
        for (int c = 0; c < 40; c++) begin
            drive(1'b1, 2'b01, 4'($urandom), 1'b1, 2'b01, 4'($urandom));
            tick();
            if (done_a || done_b) begin
                own = done_b ? 1 : 0;
                check("burst_owner", 32'(own), 32'((dones / int'(MAX_BURST)) % 2));
                run_len = (own == last_own) ? run_len + 1 : 1;
                last_own = own;
                check("burst_run_le_max", 32'(run_len <= int'(MAX_BURST)), 32'd1);
                dones++;
            end
        end
        check("burst_done_count", 32'(dones), 32'd20);
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000);
        tick();
        tick();
        tick();

        // Latched op/data survive request drop and data change during ISSUE
        drive(1'b1, 2'b01, 4'b0010, 1'b0, 2'b00, 4'b0000);
        tick();
        check("latch_issue_reg_d", 32'(reg_d), 32'h2);
        drive(1'b0, 2'b01, 4'b1000, 1'b0, 2'b00, 4'b0000);
        tick();
        check("latch_done_a", 32'(done_a), 32'd1);
        check("latch_reg_q", 32'(reg_q), 32'h2);
        tick();

        // Async reset during a SET issue abandons the transaction
        drive(1'b1, 2'b11, 4'b0000, 1'b0, 2'b00, 4'b0000);
        tick();
        check("abort_set_before", 32'(reg_set), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check("abort_async_drop", 32'({reg_set, gnt_a, busy, done_a, reg_clr}), 32'd0);
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000);
        tick();
        check("abort_no_done", 32'({done_a, done_b}), 32'd0);
        check("abort_reg_q_kept", 32'(reg_q), 32'h2);
        reset = 1'b0;
        drive(1'b1, 2'b01, 4'b0110, 1'b1, 2'b01, 4'b1001);
        tick();
        check("abort_tie_to_a", 32'({gnt_a, gnt_b}), 32'b10);
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000);
        tick();
        tick();

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 800; c++) begin
            drive(1'($urandom_range(0, 9) < 6), 2'($urandom), 4'($urandom),
                  1'($urandom_range(0, 9) < 6), 2'($urandom), 4'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
